// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: sequential radix-2 Booth multiply controller (MiniSRC MUL).
// Time-shares an external 64-bit adder, one add/sub/pass per cycle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             request, sampled only in IDLE
//   signed_op         1 = two's complement operands, 0 = unsigned
//   mcand, mplier     operands, sampled with start
//   busy              high in RUN and DONE
//   done              one-cycle pulse, hi/lo valid
//   hi, lo            upper / lower halves of the product
//   add_a, add_b      operands driven to the external adder
//   add_cin           carry-in driven to the external adder
//   add_sum           combinational sum returned by the external adder
//
// WIDTH must satisfy 2*WIDTH <= 64.
module booth_mul_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    output logic             add_cin,
    input  logic [63:0]      add_sum
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 2);

    // Product is taken modulo 2^(2*WIDTH); bits above are forced to zero.
    localparam logic [63:0] PMASK =
        (PW >= 64) ? {64{1'b1}} : ((64'd1 << PW) - 64'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [63:0]     acc;
    logic [63:0]     md;
    logic [WIDTH:0]  mq;
    logic            q_prev;
    logic [CW-1:0]   count;
    logic [CW-1:0]   iter;

    logic            q_cur;
    logic            last_step;
    logic [63:0]     sum_masked;
    logic [63:0]     md_load;
    logic [WIDTH:0]  mq_load;
    logic [CW-1:0]   iter_load;

    assign q_cur      = mq[count];
    assign sum_masked = add_sum & PMASK;

    // Signed operands are extended with their sign bit; unsigned
    // operands get a zero extension bit and one extra Booth step so the
    // top multiplier bit is never interpreted as a sign.
    assign md_load = signed_op
        ? {{(64 - WIDTH){mcand[WIDTH-1]}}, mcand}
        : {{(64 - WIDTH){1'b0}}, mcand};
    assign mq_load   = {signed_op & mplier[WIDTH-1], mplier};
    assign iter_load = signed_op ? CW'(WIDTH) : CW'(WIDTH + 1);

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 64'd0;
        add_b     = 64'd0;
        add_cin   = 1'b0;
        last_step = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                add_a = acc;
                unique case ({q_cur, q_prev})
                    2'b01: begin
                        add_b = md;
                    end
                    2'b10: begin
                        add_b   = ~md;
                        add_cin = 1'b1;
                    end
                    default: begin
                        add_b = 64'd0;
                    end
                endcase
                if (count == iter - CW'(1)) begin
                    last_step = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= 64'd0;
            md     <= 64'd0;
            mq     <= '0;
            q_prev <= 1'b0;
            count  <= '0;
            iter   <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (state == IDLE && start) begin
                acc    <= 64'd0;
                md     <= md_load;
                mq     <= mq_load;
                q_prev <= 1'b0;
                count  <= '0;
                iter   <= iter_load;
            end else if (state == RUN) begin
                acc    <= sum_masked;
                md     <= md << 1;
                q_prev <= q_cur;
                count  <= count + CW'(1);
                if (last_step) begin
                    hi <= sum_masked[PW-1:WIDTH];
                    lo <= sum_masked[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl: directed scoreboard bench for booth_mul_ctrl.
// Models the external adder and checks results, latency and handshakes.
module tb_booth_mul_ctrl;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic        add_cin;
    logic [63:0] add_sum;

    exp_t        sb[$];
    int          compared = 0;
    int          mismatched = 0;
    int          done_seen = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    booth_mul_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .signed_op (signed_op),
        .mcand     (mcand),
        .mplier    (mplier),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum)
    );

    // External carry-lookahead adder stand-in.
    assign add_sum = add_a + add_b + {63'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_done0"}, 64'(done), 64'd0);
        check({tag, "_busy0"}, 64'(busy), 64'd0);
        check({tag, "_adda0"}, add_a, 64'd0);
        check({tag, "_addb0"}, add_b, 64'd0);
        check({tag, "_cin0"}, 64'(add_cin), 64'd0);
    endtask

    // Drive a request at a falling edge; returns just after the start edge.
    task automatic issue(input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit push);
        exp_t e;
        @(negedge clk);
        start     = 1'b1;
        signed_op = sgn;
        mcand     = a;
        mplier    = b;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.lat = sgn ? 32 : 33;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    // Called at the falling edge right after the start edge.
    task automatic wait_done(input string tag);
        int   k;
        exp_t e;
        k = 0;
        check({tag, "_hold_hi"}, 64'(hi), 64'(last_hi));
        check({tag, "_hold_lo"}, 64'(lo), 64'(last_lo));
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() == 0) begin
            e.hi  = 'x;
            e.lo  = 'x;
            e.lat = -1;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_lat"}, 64'(k), 64'(e.lat));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(lo), 64'(e.lo));
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clk);
        check_idle({tag, "_after"});
    endtask

    initial begin
        exp_t e;
        int   seen;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        mcand     = '0;
        mplier    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        issue(1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
        wait_done("s7xm3");
        issue(1'b1, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0000_0000, 1);
        wait_done("sminsq");
        issue(1'b1, 32'h7FFF_FFFF, 32'h8000_0000,
              32'hC000_0000, 32'h8000_0000, 1);
        wait_done("smaxmin");
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1);
        wait_done("umax");
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0000_0000, 32'h0000_0001, 1);
        wait_done("sm1sq");
        issue(1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1);
        wait_done("zero");
        issue(1'b1, 32'd1, 32'h89AB_CDEF, 32'hFFFF_FFFF, 32'h89AB_CDEF, 1);
        wait_done("ident");

        // Start held high through RUN with operands changing mid-flight.
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b1;
        mcand     = 32'd7;
        mplier    = 32'd3;
        e.hi = 32'd0;
        e.lo = 32'h15;
        e.lat = 32;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        mcand  = 32'd100;
        mplier = 32'd200;
        begin
            int k;
            k = 0;
            while (done !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
                if (k == 5) begin
                    mcand  = 32'd5;
                    mplier = 32'd9;
                end
            end
            e = sb.pop_front();
            check("held_lat", 64'(k), 64'(e.lat));
            check("held_hi", 64'(hi), 64'(e.hi));
            check("held_lo", 64'(lo), 64'(e.lo));
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(negedge clk);
        check("held_idle_busy", 64'(busy), 64'd0);
        check("held_idle_done", 64'(done), 64'd0);
        e.hi = 32'd0;
        e.lo = 32'd45;
        e.lat = 32;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done("held_next");

        // Abort mid-RUN with a synchronous reset at count = 10.
        issue(1'b1, 32'd123, 32'd456, 32'd0, 32'd0, 0);
        repeat (10) @(negedge clk);
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        seen  = done_seen;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_nodone", 64'(done_seen), 64'(seen));
        last_hi = '0;
        last_lo = '0;
        issue(1'b1, 32'd5, 32'd6, 32'd0, 32'h1E, 1);
        wait_done("post_reset");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
